// File: rtl/rr_arbiter_exp8.sv
// rr_arbiter_exp8
// Round-robin arbiter that shares one resource among four requesters.
// Priority rotates through a 2-bit pointer. A holder keeps the grant until it
// drops its request or has held for HOLD_MAX cycles. When the grant is released
// it is handed straight to the next requester, so there is no idle gap.
//
// Parameters:
//   HOLD_MAX     maximum consecutive cycles a requester may hold the grant (1..15)
//
// Ports:
//   clockpulse   input   1   sole clock, rising-edge active
//   clear        input   1   synchronous active-high reset
//   request      input   4   level-sensitive request, bit n = requester n
//   grant_out    output  4   one-hot grant, 0000 when nothing is granted
//   grant_index  output  2   binary index of the granted requester, 0 when idle
//   grant_valid  output  1   high while a grant is active
//   expired      output  1   one-cycle pulse following a timeout-forced release
//
// All outputs come straight from flops.

module rr_arbiter_exp8 #(
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic       clockpulse,
    input  logic       clear,
    input  logic [3:0] request,
    output logic [3:0] grant_out,
    output logic [1:0] grant_index,
    output logic       grant_valid,
    output logic       expired
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [3:0] HOLD_LIMIT = 4'(HOLD_MAX);

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] hcnt_q, hcnt_d;
    logic       timeout_d;

    logic [3:0] grant_out_q, grant_out_d;
    logic       grant_valid_q, grant_valid_d;
    logic       expired_q, expired_d;

    // Returns the first set request bit, searching upward from 'start' and
    // wrapping modulo 4. The result is only used when at least one bit is set.
    function automatic logic [1:0] pick(input logic [1:0] start, input logic [3:0] req);
        logic [1:0] cand;
        logic [1:0] sel;
        logic       found;
        sel   = start;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cand = start + 2'(i);
            if (!found && req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
        return sel;
    endfunction

    // State register. clear takes priority over every other input. It puts the
    // pointer back to 0 and does not produce a release pulse.
    always_ff @(posedge clockpulse) begin
        if (clear) begin
            state_q       <= IDLE;
            ptr_q         <= 2'd0;
            idx_q         <= 2'd0;
            hcnt_q        <= 4'd0;
            grant_out_q   <= 4'b0000;
            grant_valid_q <= 1'b0;
            expired_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            idx_q         <= idx_d;
            hcnt_q        <= hcnt_d;
            grant_out_q   <= grant_out_d;
            grant_valid_q <= grant_valid_d;
            expired_q     <= expired_d;
        end
    end

    // Next-state logic. On a release, the pointer moves past the released
    // requester, and the new pointer is used at the same edge to pick the next
    // holder. A timeout where only the current holder is still requesting
    // therefore re-grants that same requester with a fresh count.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        hcnt_d    = hcnt_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (|request) begin
                    state_d = GRANT;
                    idx_d   = pick(ptr_q, request);
                    hcnt_d  = 4'd1;
                end
            end
            GRANT: begin
                if (!request[idx_q] || (hcnt_q == HOLD_LIMIT)) begin
                    // A voluntary drop outranks a timeout, so the release only
                    // counts as expired if the holder still wanted the grant.
                    timeout_d = request[idx_q];
                    ptr_d     = idx_q + 2'd1;
                    if (|request) begin
                        idx_d  = pick(idx_q + 2'd1, request);
                        hcnt_d = 4'd1;
                    end else begin
                        state_d = IDLE;
                        idx_d   = 2'd0;
                        hcnt_d  = 4'd0;
                    end
                end else begin
                    hcnt_d = hcnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic. The outputs are computed from the next state so that the
    // registered outputs line up with the state they describe.
    always_comb begin
        grant_valid_d = (state_d == GRANT);
        grant_out_d   = (state_d == GRANT) ? (4'b0001 << idx_d) : 4'b0000;
        expired_d     = timeout_d;
    end

    assign grant_out   = grant_out_q;
    assign grant_index = idx_q;
    assign grant_valid = grant_valid_q;
    assign expired     = expired_q;

endmodule

// File: tb/tb_rr_arbiter_exp8.sv
// tb_rr_arbiter_exp8
// Testbench for rr_arbiter_exp8 with HOLD_MAX = 4. It runs directed scenarios
// and then randomized traffic. Every output is checked against a behavioural
// model that applies the arbitration rules using plain integer arithmetic.

module tb_rr_arbiter_exp8;

    localparam int HOLD_MAX = 4;

    logic       clockpulse;
    logic       clear;
    logic [3:0] request;
    logic [3:0] grant_out;
    logic [1:0] grant_index;
    logic       grant_valid;
    logic       expired;

    int n_checks;
    int n_fail;

    // Reference model state, kept as plain integers.
    int m_valid;
    int m_idx;
    int m_ptr;
    int m_hcnt;
    int m_exp;

    rr_arbiter_exp8 #(.HOLD_MAX(HOLD_MAX)) dut (
        .clockpulse (clockpulse),
        .clear      (clear),
        .request    (request),
        .grant_out  (grant_out),
        .grant_index(grant_index),
        .grant_valid(grant_valid),
        .expired    (expired)
    );

    initial clockpulse = 1'b0;
    always #5 clockpulse = ~clockpulse;

    // Returns the first requester at or after p (mod 4) whose request is set.
    function automatic int first_from(input int p, input logic [3:0] req);
        for (int k = 0; k < 4; k++) begin
            if (req[(p + k) % 4]) return (p + k) % 4;
        end
        return 0;
    endfunction

    // Advances the model by one clock edge using the inputs applied at that edge.
    task automatic model_clock(input logic [3:0] req, input logic clr);
        int voluntary;
        int timeout;
        if (clr) begin
            m_valid = 0; m_idx = 0; m_ptr = 0; m_hcnt = 0; m_exp = 0;
        end else if (m_valid == 0) begin
            m_exp = 0;
            if (req != 4'b0000) begin
                m_idx = first_from(m_ptr, req); m_valid = 1; m_hcnt = 1;
            end
        end else begin
            voluntary = (req[m_idx] == 1'b0) ? 1 : 0;
            timeout   = (voluntary == 0 && m_hcnt == HOLD_MAX) ? 1 : 0;
            if (voluntary == 1 || timeout == 1) begin
                m_ptr = (m_idx + 1) % 4;
                m_exp = timeout;
                if (req != 4'b0000) begin
                    m_idx = first_from(m_ptr, req); m_hcnt = 1;
                end else begin
                    m_valid = 0; m_idx = 0; m_hcnt = 0;
                end
            end else begin
                m_hcnt = m_hcnt + 1;
                m_exp  = 0;
            end
        end
    endtask

    // Packs the expected outputs in the order {grant_out, grant_index, grant_valid, expired}.
    function automatic logic [7:0] model_vec();
        logic [3:0] oh;
        oh = (m_valid != 0) ? 4'(1 << m_idx) : 4'b0000;
        return {oh, 2'(m_idx), m_valid[0], m_exp[0]};
    endfunction

    // Drives one cycle of inputs, clocks it into the DUT and the model, and
    // returns to a sampling point 1 time unit after the edge.
    task automatic cycle(input logic [3:0] req, input logic clr);
        request = req;
        clear   = clr;
        @(posedge clockpulse);
        model_clock(req, clr);
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            cycle(4'b1111, 1'b1);
            n_checks++;
            if ({grant_out, grant_index, grant_valid, expired} !== 8'h00) begin
                n_fail++;
                $display("[TB] FAIL reset_outputs cycle %0d: got %b, want 00000000", c,
                         {grant_out, grant_index, grant_valid, expired});
            end
        end
        cycle(4'b0000, 1'b0);
    endtask

    task automatic test_single_request();
        cycle(4'b0100, 1'b0);
        n_checks++;
        if (grant_out !== 4'b0100 || grant_index !== 2'd2 || grant_valid !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL single_grant: got out=%b idx=%0d valid=%b, want out=0100 idx=2 valid=1",
                     grant_out, grant_index, grant_valid);
        end
        cycle(4'b0000, 1'b0);
        n_checks++;
        if (grant_out !== 4'b0000 || grant_valid !== 1'b0 || grant_index !== 2'd0) begin
            n_fail++;
            $display("[TB] FAIL single_release: got out=%b idx=%0d valid=%b, want out=0000 idx=0 valid=0",
                     grant_out, grant_index, grant_valid);
        end
    endtask

    task automatic test_timeout_rotation();
        logic [3:0] want_out;
        logic       want_exp;
        cycle(4'b0000, 1'b1);
        for (int c = 0; c < 17; c++) begin
            cycle(4'b1111, 1'b0);
            want_out = 4'(1 << ((c / 4) % 4));
            want_exp = (c > 0 && (c % 4) == 0);
            n_checks++;
            if (grant_out !== want_out || expired !== want_exp || grant_valid !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL timeout_rotation cycle %0d: got out=%b exp=%b valid=%b, want out=%b exp=%b valid=1",
                         c, grant_out, expired, grant_valid, want_out, want_exp);
            end
        end
        cycle(4'b0000, 1'b0);
    endtask

    task automatic test_back_to_back();
        cycle(4'b0000, 1'b1);
        cycle(4'b0011, 1'b0);
        n_checks++;
        if (grant_out !== 4'b0001) begin
            n_fail++;
            $display("[TB] FAIL handoff_first: got out=%b, want 0001", grant_out);
        end
        cycle(4'b0010, 1'b0);
        n_checks++;
        if (grant_out !== 4'b0010 || grant_valid !== 1'b1 || expired !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL handoff_direct: got out=%b valid=%b exp=%b, want out=0010 valid=1 exp=0",
                     grant_out, grant_valid, expired);
        end
    endtask

    task automatic test_pointer_fairness();
        // Requester 1 holds the grant from the previous scenario. Releasing it
        // voluntarily moves the pointer to 2.
        cycle(4'b0000, 1'b0);
        cycle(4'b0011, 1'b0);
        n_checks++;
        if (grant_out !== 4'b0001 || grant_index !== 2'd0) begin
            n_fail++;
            $display("[TB] FAIL pointer_fairness: got out=%b idx=%0d, want out=0001 idx=0",
                     grant_out, grant_index);
        end
        cycle(4'b0000, 1'b0);
    endtask

    task automatic test_reset_mid_grant();
        cycle(4'b0000, 1'b1);
        cycle(4'b1000, 1'b0);
        n_checks++;
        if (grant_out !== 4'b1000 || grant_index !== 2'd3) begin
            n_fail++;
            $display("[TB] FAIL midreset_grant3: got out=%b idx=%0d, want out=1000 idx=3",
                     grant_out, grant_index);
        end
        cycle(4'b1000, 1'b1);
        n_checks++;
        if ({grant_out, grant_index, grant_valid, expired} !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL midreset_clear: got %b, want 00000000",
                     {grant_out, grant_index, grant_valid, expired});
        end
        cycle(4'b1010, 1'b0);
        n_checks++;
        if (grant_out !== 4'b0010 || grant_index !== 2'd1 || expired !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL midreset_restart: got out=%b idx=%0d exp=%b, want out=0010 idx=1 exp=0",
                     grant_out, grant_index, expired);
        end
    endtask

    task automatic test_random();
        logic [3:0] req;
        logic       clr;
        logic [7:0] got;
        logic [7:0] want;
        req = 4'b0000;
        cycle(4'b0000, 1'b1);
        for (int c = 0; c < 400; c++) begin
            // Keep the previous request half the time so that holds and timeouts happen.
            if ($urandom_range(0, 1) == 0) req = 4'($urandom_range(0, 15));
            clr = ($urandom_range(0, 39) == 0);
            cycle(req, clr);
            got  = {grant_out, grant_index, grant_valid, expired};
            want = model_vec();
            n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("[TB] FAIL random cycle %0d req=%b clr=%b: got {out,idx,valid,exp}=%b, want %b",
                         c, req, clr, got, want);
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_valid = 0; m_idx = 0; m_ptr = 0; m_hcnt = 0; m_exp = 0;
        request = 4'b0000;
        clear   = 1'b1;
        test_reset();
        test_single_request();
        test_timeout_rotation();
        test_back_to_back();
        test_pointer_fairness();
        test_reset_mid_grant();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
